// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle main control unit.
// IMM_ALU_EN adds the addi states (ADDIEXEC, ADDICOMPLETE).
package control_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAddr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecute,
      StRComplete,
      StBranch,
      StJump
`ifdef IMM_ALU_EN
      ,
      StAddiExec,
      StAddiComplete
`endif
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_ADDI  = 6'd8;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_IMM   = 2'b11;

   localparam logic [1:0] ALUSRCB_B     = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_SHIMM = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
   } ctrl_word_t;

endpackage

// File: rtl/control_word_decode.sv
// Pure state -> control word mapping for the main control FSM.
// IMM_ALU_EN adds the addi execute/complete words.
module control_word_decode
   import control_pkg::*;
(
   input  state_e     i_state,
   input  logic       i_mem_ready,
   output ctrl_word_t o_ctrl
);

   always_comb begin
      o_ctrl           = '0;
      o_ctrl.alu_op    = ALUOP_ADD;
      o_ctrl.alu_src_b = ALUSRCB_B;
      o_ctrl.pc_source = PCSRC_ALU;
      unique case (i_state)
         StFetch: begin
            o_ctrl.mem_read  = 1'b1;
            // PC and IR only load once the fetch actually completes
            o_ctrl.ir_write  = i_mem_ready;
            o_ctrl.pc_write  = i_mem_ready;
            o_ctrl.alu_src_b = ALUSRCB_FOUR;
         end
         StDecode: begin
            o_ctrl.alu_src_b = ALUSRCB_SHIMM;
         end
         StMemAddr: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = ALUSRCB_IMM;
         end
         StMemRead: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.i_or_d   = 1'b1;
         end
         StMemWb: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
         end
         StMemWrite: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.i_or_d    = 1'b1;
         end
         StExecute: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         StRComplete: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.reg_dst   = 1'b1;
         end
         StBranch: begin
            o_ctrl.alu_src_a     = 1'b1;
            o_ctrl.pc_write_cond = 1'b1;
            o_ctrl.alu_op        = ALUOP_SUB;
            o_ctrl.pc_source     = PCSRC_ALUOUT;
         end
         StJump: begin
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.pc_source = PCSRC_JUMP;
         end
`ifdef IMM_ALU_EN
         StAddiExec: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = ALUSRCB_IMM;
            o_ctrl.alu_op    = ALUOP_IMM;
         end
         StAddiComplete: begin
            o_ctrl.reg_write = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control FSM: state register, opcode latch and next-state logic.
// Define IMM_ALU_EN to make opcode 8 (addi) a legal instruction.
module main_control_fsm
   import control_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic [1:0] AluOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       illegal_op
);

   state_e     r_state;
   state_e     w_next;
   logic [5:0] r_opcode;
   logic       w_illegal;
   ctrl_word_t w_ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= StFetch;
         r_opcode <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == StDecode) begin
            r_opcode <= opcode;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      w_illegal = 1'b0;
      unique case (r_state)
         StFetch:     if (mem_ready) w_next = StDecode;
         StDecode: begin
            case (opcode)
               OP_LW, OP_SW: w_next = StMemAddr;
               OP_RTYPE:     w_next = StExecute;
               OP_BEQ:       w_next = StBranch;
               OP_J:         w_next = StJump;
`ifdef IMM_ALU_EN
               OP_ADDI:      w_next = StAddiExec;
`endif
               default: begin
                  w_next    = StFetch;
                  w_illegal = 1'b1;
               end
            endcase
         end
         // Only lw/sw reach MEMADDR, so the latch picks between the two
         StMemAddr:   w_next = (r_opcode == OP_SW) ? StMemWrite : StMemRead;
         StMemRead:   if (mem_ready) w_next = StMemWb;
         StMemWrite:  if (mem_ready) w_next = StFetch;
         StExecute:   w_next = StRComplete;
         StMemWb,
         StRComplete,
         StBranch,
         StJump:      w_next = StFetch;
`ifdef IMM_ALU_EN
         StAddiExec:     w_next = StAddiComplete;
         StAddiComplete: w_next = StFetch;
`endif
         default:     w_next = StFetch;
      endcase
   end

   control_word_decode u_decode (
      .i_state     (r_state),
      .i_mem_ready (mem_ready),
      .o_ctrl      (w_ctrl)
   );

   // Reset forces every output low, even mid-instruction
   always_comb begin
      AluOp       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      illegal_op  = 1'b0;
      if (!rst) begin
         AluOp       = w_ctrl.alu_op;
         ALUSrcA     = w_ctrl.alu_src_a;
         ALUSrcB     = w_ctrl.alu_src_b;
         PCSource    = w_ctrl.pc_source;
         PCWrite     = w_ctrl.pc_write;
         PCWriteCond = w_ctrl.pc_write_cond;
         IorD        = w_ctrl.i_or_d;
         MemRead     = w_ctrl.mem_read;
         MemWrite    = w_ctrl.mem_write;
         MemtoReg    = w_ctrl.mem_to_reg;
         IRWrite     = w_ctrl.ir_write;
         RegWrite    = w_ctrl.reg_write;
         RegDst      = w_ctrl.reg_dst;
         illegal_op  = w_illegal;
      end
   end

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized bench for main_control_fsm against an instruction-level step model.
// Honours IMM_ALU_EN for the legality of opcode 8.
module tb_main_control_fsm;

   localparam int SF  = 0;
   localparam int SD  = 1;
   localparam int SMA = 2;
   localparam int SMR = 3;
   localparam int SWB = 4;
   localparam int SMW = 5;
   localparam int SEX = 6;
   localparam int SRC = 7;
   localparam int SBR = 8;
   localparam int SJP = 9;
   localparam int SAE = 10;
   localparam int SAC = 11;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic [1:0] AluOp;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSource;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       IRWrite;
   logic       RegWrite;
   logic       RegDst;
   logic       illegal_op;

   main_control_fsm dut (
      .clk         (clk),
      .rst         (rst),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .AluOp       (AluOp),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .PCSource    (PCSource),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemtoReg    (MemtoReg),
      .IRWrite     (IRWrite),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .illegal_op  (illegal_op)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_cycle  = 0;
   int         q[$];
   logic [5:0] op_cur;
   logic [5:0] next_op;

   task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%05h exp=%05h (AluOp got %b exp %b)", tag, got, exp,
                  got[16:15], exp[16:15]);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
`ifdef IMM_ALU_EN
      if (op == 6'd8) return 1'b1;
`endif
      return (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) || (op == 6'd2);
   endfunction

   function automatic string step_name(input int s);
      case (s)
         SF:      return "FETCH";
         SD:      return "DECODE";
         SMA:     return "MEMADDR";
         SMR:     return "MEMREAD";
         SWB:     return "MEMWB";
         SMW:     return "MEMWRITE";
         SEX:     return "EXECUTE";
         SRC:     return "RCOMPLETE";
         SBR:     return "BRANCH";
         SJP:     return "JUMP";
         SAE:     return "ADDIEXEC";
         default: return "ADDICOMPLETE";
      endcase
   endfunction

   // Expected outputs per step, straight from the state/output table
   function automatic logic [16:0] exp_out(input int s, input logic rdy, input logic [5:0] op);
      logic [1:0] aop, srcb, pcs;
      logic       srca, pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, ill;
      aop = 2'b00; srcb = 2'b00; pcs = 2'b00;
      srca = 0; pcw = 0; pcwc = 0; iord = 0; mr = 0; mw = 0;
      m2r = 0; irw = 0; rw = 0; rd = 0; ill = 0;
      case (s)
         SF:  begin mr = 1; irw = rdy; pcw = rdy; srcb = 2'b01; end
         SD:  begin srcb = 2'b11; ill = !is_legal(op); end
         SMA: begin srca = 1; srcb = 2'b10; end
         SMR: begin mr = 1; iord = 1; end
         SWB: begin rw = 1; m2r = 1; end
         SMW: begin mw = 1; iord = 1; end
         SEX: begin srca = 1; aop = 2'b10; end
         SRC: begin rw = 1; rd = 1; end
         SBR: begin srca = 1; pcwc = 1; aop = 2'b01; pcs = 2'b01; end
         SJP: begin pcw = 1; pcs = 2'b10; end
         SAE: begin srca = 1; srcb = 2'b10; aop = 2'b11; end
         default: rw = 1;
      endcase
      return {aop, srca, srcb, pcs, pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, ill};
   endfunction

   task automatic push_rest(input logic [5:0] op);
      case (op)
         6'd35: begin q.push_back(SMA); q.push_back(SMR); q.push_back(SWB); end
         6'd43: begin q.push_back(SMA); q.push_back(SMW); end
         6'd0:  begin q.push_back(SEX); q.push_back(SRC); end
         6'd4:  q.push_back(SBR);
         6'd2:  q.push_back(SJP);
         default: begin
`ifdef IMM_ALU_EN
            if (op == 6'd8) begin q.push_back(SAE); q.push_back(SAC); end
`endif
         end
      endcase
   endtask

   // One clock of stimulus, check and model advance
   task automatic cycle(input logic rst_v, input logic rdy_v);
      int          s;
      logic [16:0] got, exp;
      if (q.size() == 0) begin
         op_cur = next_op;
         q.push_back(SF);
         q.push_back(SD);
      end
      s = q[0];
      @(negedge clk);
      rst       = rst_v;
      mem_ready = rdy_v;
      opcode    = (s == SD && !rst_v) ? op_cur : 6'($urandom);
      #1;
      got = {AluOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD, MemRead,
             MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, illegal_op};
      exp = rst_v ? 17'd0 : exp_out(s, rdy_v, op_cur);
      check_eq($sformatf("c%0d op%0d %s%s", n_cycle, op_cur, rst_v ? "RESET/" : "",
                         step_name(s)), got, exp);
      n_cycle++;
      if (rst_v) begin
         q.delete();
      end else if ((s == SF || s == SMR || s == SMW) && !rdy_v) begin
         // stalled: stay in the same step
      end else begin
         void'(q.pop_front());
         if (s == SD) push_rest(op_cur);
      end
   endtask

   task automatic run_instr(input logic [5:0] op);
      next_op = op;
      do cycle(1'b0, 1'b1); while (q.size() != 0);
   endtask

   initial begin
      rst       = 1'b1;
      mem_ready = 1'b0;
      opcode    = 6'd0;
      next_op   = 6'd0;
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);

      run_instr(6'd35);
      run_instr(6'd0);
      run_instr(6'd4);
      run_instr(6'd2);

      // sw with three stalled MEMWRITE cycles
      next_op = 6'd43;
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);

      // reset held 3 cycles mid-MEMWRITE, then a stalled fetch
      next_op = 6'd43;
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b1);
      next_op = 6'd35;
      cycle(1'b0, 1'b0);
      do cycle(1'b0, 1'b1); while (q.size() != 0);

      run_instr(6'd8);
      run_instr(6'd63);

      for (int i = 0; i < 800; i++) begin
         if (q.size() == 0) begin
            case ($urandom_range(0, 7))
               0:       next_op = 6'd0;
               1:       next_op = 6'd35;
               2:       next_op = 6'd43;
               3:       next_op = 6'd4;
               4:       next_op = 6'd2;
               5:       next_op = 6'd8;
               default: next_op = 6'($urandom_range(0, 63));
            endcase
         end
         cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
